// File: rtl/regfile_debug_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | regfile_debug_arbiter_pkg                                                  |
// | Shared widths, FSM state encoding and latched-request record for the       |
// | register-file debug arbiter.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package regfile_debug_arbiter_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int REG_ADDR_WIDTH    = 5;
  localparam int STRB_WIDTH        = DATA_WIDTH / 8;
  localparam int TIMEOUT_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STOP  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4,
    ST_GAP   = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [STRB_WIDTH-1:0]     wstrb;
  } dbg_txn_t;

endpackage

`default_nettype wire

// File: rtl/regfile_debug_arbiter_strobe_merge.sv
// +----------------------------------------------------------------------------+
// | strobe_merge                                                               |
// | Combinational byte-strobed merge of new write data over an old value.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module strobe_merge
  import regfile_debug_arbiter_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] old,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic [DATA_WIDTH-1:0] merged
);

  for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_byte
    assign merged[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/regfile_debug_arbiter.sv
// +----------------------------------------------------------------------------+
// | regfile_debug_arbiter                                                      |
// | Stalls the core, then performs a strobed read-modify-write or read on the  |
// | register file for the debug master. Optional STOP timeout is enabled by    |
// | defining REGFILE_ARB_TIMEOUT_EN.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_debug_arbiter
  import regfile_debug_arbiter_pkg::*;
#(
  parameter int STOP_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0]     dbg_wdata,
  input  logic [STRB_WIDTH-1:0]     dbg_wstrb,
  output logic                      dbg_ack,
  output logic [DATA_WIDTH-1:0]     dbg_rdata,
  output logic                      dbg_err,
  output logic                      cpu_stop,
  input  logic                      cpu_idle,
  input  logic                      core_we,
  input  logic [REG_ADDR_WIDTH-1:0] core_waddr,
  input  logic [DATA_WIDTH-1:0]     core_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] core_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] core_rs2_addr,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0]     rf_rs1
);

  localparam logic [TIMEOUT_CNT_WIDTH-1:0] c_TIMEOUT_LAST =
    TIMEOUT_CNT_WIDTH'(STOP_TIMEOUT - 1);

  arb_state_t            r_state;
  dbg_txn_t              r_txn;
  dbg_txn_t              w_req_txn;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_timeout;
  logic                  w_addr_zero;

  assign w_req_txn   = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata, wstrb: dbg_wstrb};
  assign w_addr_zero = (r_txn.addr == '0);

  strobe_merge u_strobe_merge (
    .old    (rf_rs1),
    .wdata  (r_txn.wdata),
    .wstrb  (r_txn.wstrb),
    .merged (w_merged)
  );

`ifdef REGFILE_ARB_TIMEOUT_EN
  logic [TIMEOUT_CNT_WIDTH-1:0] r_stop_cnt;
  logic                         r_err;

  assign w_timeout = (r_state == ST_STOP) && !cpu_idle && (r_stop_cnt == c_TIMEOUT_LAST);
  assign dbg_err   = r_err;

  // Counts only stalled STOP cycles; any other state rearms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop_cnt <= '0;
    end else if (r_state != ST_STOP) begin
      r_stop_cnt <= '0;
    end else if (!cpu_idle) begin
      r_stop_cnt <= r_stop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (r_state == ST_WRITE) begin
      r_err <= 1'b0;
    end
  end
`else
  wire w_unused_timeout = ^c_TIMEOUT_LAST;

  assign w_timeout = 1'b0;
  assign dbg_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_txn     <= '0;
      cpu_stop  <= 1'b0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dbg_req) begin
            r_txn    <= w_req_txn;
            cpu_stop <= 1'b1;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cpu_idle) begin
            r_state <= ST_READ;
          end else if (w_timeout) begin
            dbg_rdata <= '0;
            dbg_ack   <= 1'b1;
            r_state   <= ST_ACK;
          end
        end
        ST_READ: begin
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          dbg_rdata <= w_addr_zero ? '0 : rf_rs1;
          dbg_ack   <= 1'b1;
          r_state   <= ST_ACK;
        end
        ST_ACK: begin
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          // The core is still stopped, so a new request skips the drain wait.
          if (dbg_req) begin
            r_txn   <= w_req_txn;
            r_state <= ST_READ;
          end else begin
            cpu_stop <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          cpu_stop <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_rs1_addr = r_txn.addr;
    rf_rs2_addr = '0;
    case (r_state)
      ST_IDLE, ST_STOP: begin
        rf_we       = core_we;
        rf_waddr    = core_waddr;
        rf_wdata    = core_wdata;
        rf_rs1_addr = core_rs1_addr;
        rf_rs2_addr = core_rs2_addr;
      end
      ST_WRITE: begin
        if (r_txn.we && !w_addr_zero) begin
          rf_we    = 1'b1;
          rf_waddr = r_txn.addr;
          rf_wdata = w_merged;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_debug_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_debug_arbiter                                                   |
// | Self-checking bench: register-file environment plus reference model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_debug_arbiter;
  import regfile_debug_arbiter_pkg::*;

  localparam int c_TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [3:0]  dbg_wstrb;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        dbg_err;
  logic        cpu_stop, cpu_idle;
  logic        core_we;
  logic [4:0]  core_waddr, core_rs1_addr, core_rs2_addr;
  logic [31:0] core_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr, rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_wdata, rf_rs1;

  int checks = 0;
  int errors = 0;

  regfile_debug_arbiter #(.STOP_TIMEOUT(c_TB_TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .cpu_stop(cpu_stop), .cpu_idle(cpu_idle),
    .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_rs1_addr(core_rs1_addr), .core_rs2_addr(core_rs2_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr), .rf_rs1(rf_rs1)
  );

  always #5 clk = ~clk;

  // Register-file environment: synchronous read, x0 hardwired to zero.
  logic [31:0] rf_mem [32];
  logic        env_clear;
  int          rf_we_count = 0;

  always @(posedge clk) begin
    rf_rs1 <= rf_mem[rf_rs1_addr];
    if (env_clear) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
    end else if (rf_we) begin
      rf_we_count <= rf_we_count + 1;
      if (rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  // Reference model: architectural register contents.
  logic [31:0] ref_mem [32];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic ref_access(input logic we, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] exp_rdata);
    exp_rdata = (a == 5'd0) ? 32'd0 : ref_mem[a];
    if (we && a != 5'd0) ref_mem[a] = merge_bytes(ref_mem[a], d, s);
  endtask

  task automatic core_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    core_we = 1'b1; core_waddr = a; core_wdata = d;
    @(negedge clk);
    core_we = 1'b0;
    if (a != 5'd0) ref_mem[a] = d;
  endtask

  // Lat counts rising edges from the request sample to the cycle where ack is seen.
  task automatic do_txn(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int delay, input bit scramble,
                        input bit wait_release, output int lat, output logic [31:0] rdata,
                        output logic err, output bit stop_ok, output bit rel_ok);
    int n;
    n = 0; lat = -1; rdata = 32'd0; err = 1'b0; stop_ok = 1'b1; rel_ok = 1'b1;
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_wstrb = s;
    cpu_idle = (delay == 0);
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (scramble) begin
        dbg_we = 1'($urandom); dbg_addr = 5'($urandom);
        dbg_wdata = $urandom; dbg_wstrb = 4'($urandom);
      end
      if (n == delay + 1) begin
        cpu_idle = 1'b1;
        core_we  = 1'b0;
      end
      @(negedge clk);
      if (!cpu_stop) stop_ok = 1'b0;
      if (dbg_ack) begin
        lat = n; rdata = dbg_rdata; err = dbg_err;
        break;
      end
    end
    dbg_req = 1'b0;
    if (wait_release) begin
      @(negedge clk);
      if (!cpu_stop || dbg_ack) rel_ok = 1'b0;
      @(negedge clk);
      if (cpu_stop) rel_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (cpu_stop !== 1'b0) begin errors++; $display("FAIL reset_cpu_stop: got %b want 0", cpu_stop); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", dbg_ack); end
    checks++; if (dbg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", dbg_err); end
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
    core_rs1_addr = 5'd9; core_rs2_addr = 5'd17;
    #1;
    checks++;
    if (rf_rs1_addr !== 5'd9 || rf_rs2_addr !== 5'd17 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_passthrough: got rs1=%0d rs2=%0d we=%b want 9 17 0",
               rf_rs1_addr, rf_rs2_addr, rf_we);
    end
  endtask

  task automatic test_read();
    int lat; logic [31:0] rd, exp; logic err; bit sok, rok;
    core_write(5'd1, 32'hDEADBEEF);
    ref_access(1'b0, 5'd1, 32'd0, 4'd0, exp);
    do_txn(1'b0, 5'd1, 32'h0, 4'h0, 0, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (rd !== exp) begin errors++; $display("FAIL read_rdata: got %h want %h", rd, exp); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d want 4", lat); end
    checks++; if (!(sok && rok && !err)) begin errors++; $display("FAIL read_handshake: got stop=%b rel=%b err=%b want 1 1 0", sok, rok, err); end
  endtask

  task automatic test_strobed_write();
    int lat; logic [31:0] rd, exp; logic err; bit sok, rok;
    core_write(5'd2, 32'hFFFFFFFF);
    ref_access(1'b1, 5'd2, 32'h00AA5500, 4'b0110, exp);
    do_txn(1'b1, 5'd2, 32'h00AA5500, 4'b0110, 0, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (rd !== exp) begin errors++; $display("FAIL strobe_old_rdata: got %h want %h", rd, exp); end
    ref_access(1'b0, 5'd2, 32'd0, 4'd0, exp);
    do_txn(1'b0, 5'd2, 32'h0, 4'h0, 0, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (rd !== exp || exp !== 32'hFFAA55FF) begin errors++; $display("FAIL strobe_merged: got %h want FFAA55FF", rd); end
  endtask

  task automatic test_delayed_drain();
    int lat; logic [31:0] rd, exp; logic err; bit sok, rok;
    core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'h12;
    ref_mem[3] = 32'h12;
    ref_access(1'b0, 5'd3, 32'd0, 4'd0, exp);
    do_txn(1'b0, 5'd3, 32'h0, 4'h0, 3, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (rd !== exp) begin errors++; $display("FAIL drain_rdata: got %h want %h", rd, exp); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL drain_latency: got %0d want 7", lat); end
  endtask

  task automatic test_x0();
    int lat, cnt0; logic [31:0] rd, exp; logic err; bit sok, rok;
    cnt0 = rf_we_count;
    ref_access(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, exp);
    do_txn(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (lat !== 4 || err !== 1'b0) begin errors++; $display("FAIL x0_write_ack: got lat=%0d err=%b want 4 0", lat, err); end
    do_txn(1'b0, 5'd0, 32'h0, 4'h0, 0, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL x0_read: got %h want 0", rd); end
    checks++; if (rf_we_count !== cnt0) begin errors++; $display("FAIL x0_no_we: got %0d writes want 0", rf_we_count - cnt0); end
  endtask

  task automatic test_back_to_back();
    int lat, n; logic [31:0] rd, exp1, exp2; logic err; bit sok, rok, held;
    logic [4:0] a2; logic [31:0] d2; logic [3:0] s2;
    a2 = 5'd10 + 5'($urandom_range(0, 15)); d2 = $urandom; s2 = 4'($urandom);
    ref_access(1'b1, 5'd7, 32'hA5A5A5A5, 4'b1001, exp1);
    ref_access(1'b1, a2, d2, s2, exp2);
    do_txn(1'b1, 5'd7, 32'hA5A5A5A5, 4'b1001, 1, 1'b0, 1'b0, lat, rd, err, sok, rok);
    checks++; if (rd !== exp1) begin errors++; $display("FAIL b2b_first_rdata: got %h want %h", rd, exp1); end
    @(negedge clk);
    held = cpu_stop;
    checks++;
    if (rf_we !== 1'b0 || rf_rs2_addr !== 5'd0) begin
      errors++; $display("FAIL b2b_gap_ports: got we=%b rs2=%0d want 0 0", rf_we, rf_rs2_addr);
    end
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a2; dbg_wdata = d2; dbg_wstrb = s2;
    n = 0; lat = -1;
    while (n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!cpu_stop) held = 1'b0;
      if (dbg_ack) begin lat = n; rd = dbg_rdata; break; end
    end
    dbg_req = 1'b0;
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    checks++; if (rd !== exp2) begin errors++; $display("FAIL b2b_second_rdata: got %h want %h", rd, exp2); end
    checks++; if (!held) begin errors++; $display("FAIL b2b_stop_held: got drop want held"); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (cpu_stop !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b want 0", cpu_stop); end
  endtask

  task automatic test_reset_mid();
    int lat, cnt0; logic [31:0] rd, old, exp; logic err; bit sok, rok;
    core_write(5'd5, $urandom);
    old = ref_mem[5];
    cnt0 = rf_we_count;
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = ~old; dbg_wstrb = 4'hF;
    cpu_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_stop, dbg_ack, dbg_err, rf_we} !== 4'b0 || dbg_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got stop=%b ack=%b err=%b we=%b rdata=%h want all 0",
               cpu_stop, dbg_ack, dbg_err, rf_we, dbg_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rf_we_count !== cnt0) begin errors++; $display("FAIL reset_mid_no_write: got %0d writes want 0", rf_we_count - cnt0); end
    ref_access(1'b0, 5'd5, 32'd0, 4'd0, exp);
    do_txn(1'b0, 5'd5, 32'h0, 4'h0, 0, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (rd !== exp) begin errors++; $display("FAIL reset_mid_value: got %h want %h", rd, exp); end
  endtask

  task automatic test_random();
    int lat, dly; logic [31:0] rd, exp, d; logic err; bit sok, rok; logic we; logic [4:0] a; logic [3:0] s;
    for (int k = 0; k < 24; k++) begin
      we = 1'($urandom); a = 5'($urandom); d = $urandom; s = 4'($urandom);
      dly = $urandom_range(0, 2);
      ref_access(we, a, d, s, exp);
      do_txn(we, a, d, s, dly, 1'b1, 1'b1, lat, rd, err, sok, rok);
      checks++; if (rd !== exp) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rd, exp); end
      checks++;
      if (lat !== 4 + dly || !sok || !rok || err) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got lat=%0d stop=%b rel=%b err=%b want %0d 1 1 0", k, lat, sok, rok, err, 4 + dly);
      end
    end
    for (int i = 1; i < 32; i++) begin
      checks++;
      if (rf_mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_regfile[x%0d]: got %h want %h", i, rf_mem[i], ref_mem[i]); end
    end
  endtask

`ifdef REGFILE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int lat, cnt0; logic [31:0] rd, exp; logic err; bit sok, rok;
    cnt0 = rf_we_count;
    do_txn(1'b1, 5'd1, 32'h0, 4'hF, 1000, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (lat !== c_TB_TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", lat, c_TB_TIMEOUT + 1); end
    checks++; if (err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL timeout_err: got err=%b rdata=%h want 1 0", err, rd); end
    checks++; if (!rok || rf_we_count !== cnt0) begin errors++; $display("FAIL timeout_release: got rel=%b writes=%0d want 1 0", rok, rf_we_count - cnt0); end
    ref_access(1'b0, 5'd1, 32'd0, 4'd0, exp);
    do_txn(1'b0, 5'd1, 32'h0, 4'h0, 0, 1'b0, 1'b1, lat, rd, err, sok, rok);
    checks++; if (err !== 1'b0 || rd !== exp) begin errors++; $display("FAIL timeout_recover: got err=%b rdata=%h want 0 %h", err, rd, exp); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; env_clear = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = '0;
    cpu_idle = 1'b1;
    core_we = 1'b0; core_waddr = '0; core_wdata = '0; core_rs1_addr = '0; core_rs2_addr = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    env_clear = 1'b0;
    rst_n = 1'b1;
    test_reset();
    test_read();
    test_strobed_write();
    test_delayed_drain();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef REGFILE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
